uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an input FIFO, runtime-programmable baud rate, and configurable frame format. The baud generator is a 16-bit phase-accumulator NCO. It sits between a bus/register master that pushes bytes and the `txd` pad, and it replaces the fixed 8-data-bit, 2-stop-bit, single-byte transmitter. Frames go out back-to-back, with no idle gap, for as long as the FIFO holds data.

---
 rtl/uart_tx_fifo_if.sv | 28 ++
 rtl/uart_tx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the FIFO-buffered UART transmitter.
// The master pushes characters and picks the bit rate. The slave (the
// transmitter) reports FIFO status, activity and the serial line.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                 wr_en;
    logic [DATA_BITS-1:0] wr_data;
    logic [15:0]          baud_inc;
    logic                 full;
    logic [LW-1:0]        level;
    logic                 overflow;
    logic                 busy;
    logic                 txd;

    modport master (
        output wr_en, wr_data, baud_inc,
        input  full, level, overflow, busy, txd
    );

    modport slave (
        input  wr_en, wr_data, baud_inc,
        output full, level, overflow, busy, txd
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO and a 16-bit phase-accumulator baud NCO.
// Frames are sent back-to-back while the FIFO holds data. The next character
// is popped on the same edge as the final stop tick, so no idle bit is inserted.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam longint unsigned DEF_INC_L =
        (longint'(BAUD) * 64'd65536) / longint'(CLK_HZ);
    localparam logic [15:0] DEFAULT_INC = 16'(DEF_INC_L);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [LW-1:0]        level_q;
    logic                 overflow_q;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic                 head_parity;

    assign full        = (level_q == LW'(FIFO_DEPTH));
    assign push        = bus.wr_en && !full;
    assign head        = mem[rd_ptr_q];
    // Even parity is the XOR of the data bits; odd parity is its inverse.
    assign head_parity = (^head) ^ (PARITY == 2);

    // Storage array: written on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    // Pointers, occupancy and the overflow pulse. Overflow uses full before any
    // same-cycle pop, so a write into a full FIFO is always dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= bus.wr_en && full;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    // ---------------- Baud NCO ----------------
    logic [15:0] acc_q;
    logic [15:0] inc_q;
    logic [16:0] acc_sum;
    logic [15:0] inc_sel;
    logic        tick;

    assign acc_sum = {1'b0, acc_q} + {1'b0, inc_q};
    assign tick    = acc_sum[16];
    assign inc_sel = (bus.baud_inc == 16'd0) ? DEFAULT_INC : bus.baud_inc;

    // Accumulator runs freely. Each frame start restarts it from zero with a
    // freshly latched increment, so the first bit period is exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            inc_q <= DEFAULT_INC;
        end else if (pop) begin
            acc_q <= '0;
            inc_q <= inc_sel;
        end else begin
            acc_q <= acc_sum[15:0];
        end
    end

    // ---------------- Frame state machine ----------------
    state_t               state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic [3:0]           cnt_q;
    logic                 txd_q;
    logic                 busy_q;
    logic                 stop_done;

    assign stop_done = (state_q == S_STOP) && tick && (cnt_q == 4'(STOP_BITS - 1));
    assign pop       = (level_q != '0) && ((state_q == S_IDLE) || stop_done);

    // Sequences start/data/parity/stop bits. txd and busy are registered
    // alongside the state so the pad never sees a decode glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            cnt_q    <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else if (pop) begin
            state_q  <= S_START;
            shift_q  <= head;
            parity_q <= head_parity;
            cnt_q    <= '0;
            txd_q    <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
                S_START: begin
                    if (tick) begin
                        state_q <= S_DATA;
                        txd_q   <= shift_q[0];
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift_q <= shift_q >> 1;
                        if (cnt_q == 4'(DATA_BITS - 1)) begin
                            cnt_q <= '0;
                            if (PARITY != 0) begin
                                state_q <= S_PARITY;
                                txd_q   <= parity_q;
                            end else begin
                                state_q <= S_STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                            txd_q <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        state_q <= S_STOP;
                        txd_q   <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (cnt_q == 4'(STOP_BITS - 1)) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            txd_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.full     = full;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = busy_q;
    assign bus.txd      = txd_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1, 7E2, 7O2; depth 4) share the
// same write stimulus. Each instance has a monitor that pops the expected
// character and increment from its queue when a start bit appears. It then
// checks every clock of the frame against bit boundaries at ceil(k*65536/inc).
module tb_uart_tx_fifo;
    localparam int NI      = 3;
    localparam int DEPTH   = 4;
    localparam int DEF_INC = int'((64'd115200 * 64'd65536) / 64'd100_000_000);

    logic            clk;
    logic            rst_n;
    logic            wr_en_s;
    logic [7:0]      wr_data_s;
    logic [15:0]     baud_inc_s;
    logic [NI-1:0]   txd_w;
    logic [NI-1:0]   busy_w;
    logic [NI-1:0]   full_w;
    logic [NI-1:0]   ovf_w;
    logic [2:0]      level_w [NI];
    logic            mon_en;
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int unsigned     exp_q [NI][$];
    int              b2b_cnt [NI] = '{default: 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int frame_bits(input int i);
        int db, par, sb;
        db  = (i == 0) ? 8 : 7;
        par = i;
        sb  = (i == 0) ? 1 : 2;
        return 1 + db + ((par != 0) ? 1 : 0) + sb;
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int DB  = (gi == 0) ? 8 : 7;
        localparam int PAR = gi;
        localparam int SB  = (gi == 0) ? 1 : 2;

        uart_tx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus_if ();

        assign bus_if.wr_en    = wr_en_s;
        assign bus_if.wr_data  = wr_data_s[DB-1:0];
        assign bus_if.baud_inc = baud_inc_s;
        assign txd_w[gi]       = bus_if.txd;
        assign busy_w[gi]      = bus_if.busy;
        assign full_w[gi]      = bus_if.full;
        assign ovf_w[gi]       = bus_if.overflow;
        assign level_w[gi]     = bus_if.level;

        uart_tx_fifo #(
            .DATA_BITS (DB),
            .PARITY    (PAR),
            .STOP_BITS (SB),
            .FIFO_DEPTH(DEPTH),
            .CLK_HZ    (100_000_000),
            .BAUD      (115200)
        ) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus_if)
        );

        // Frame monitor: builds the expected bit list from the character and
        // checks txd on every clock of the frame.
        initial begin : mon
            int unsigned e;
            int          d, inc, n, total, b, p, start_cyc, last_end, bad_t, bad_b;
            int          bits [16];
            bit          ok, have_last;
            have_last = 1'b0;
            last_end  = 0;
            forever begin
                @(negedge clk);
                if (mon_en && txd_w[gi] == 1'b0) begin
                    if (exp_q[gi].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame inst %0d cycle %0d: got start bit, required none", gi, cyc);
                        for (int k = 0; k < 5000 && txd_w[gi] == 1'b0; k++) @(negedge clk);
                    end else begin
                        e   = exp_q[gi].pop_front();
                        d   = int'(e & 32'h0000_FFFF) & ((1 << DB) - 1);
                        inc = int'(e >> 16);
                        n = 0;
                        bits[n] = 0; n++;
                        p = 0;
                        for (int i = 0; i < DB; i++) begin
                            bits[n] = (d >> i) & 1;
                            p ^= bits[n];
                            n++;
                        end
                        if (PAR != 0) begin
                            bits[n] = (PAR == 2) ? (p ^ 1) : p;
                            n++;
                        end
                        for (int i = 0; i < SB; i++) begin
                            bits[n] = 1; n++;
                        end
                        total     = (n * 65536 + inc - 1) / inc;
                        start_cyc = cyc;
                        if (have_last && start_cyc == last_end) b2b_cnt[gi]++;
                        ok = 1'b1; b = 0; bad_t = 0; bad_b = 0;
                        for (int t = 0; t < total; t++) begin
                            if (t > 0) @(negedge clk);
                            while ((b + 1) * 65536 <= t * inc) b++;
                            if (ok && txd_w[gi] !== bits[b][0]) begin
                                ok = 1'b0; bad_t = t; bad_b = b;
                            end
                        end
                        last_end  = start_cyc + total;
                        have_last = 1'b1;
                        checks++;
                        if (!ok) begin
                            errors++;
                            $display("FAIL frame inst %0d data 0x%02h inc %0d: txd wrong at bit %0d clock %0d, required %0d",
                                     gi, d, inc, bad_b, bad_t, bits[bad_b]);
                        end else begin
                            $display("tx inst %0d data 0x%02h inc %0d bits %0d clocks %0d ok", gi, d, inc, n, total);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int inst, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s inst %0d: got %0d, required %0d", name, inst, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input int inc);
        int unsigned v;
        v = (32'((inc == 0) ? DEF_INC : inc) << 16) | 32'(d);
        for (int i = 0; i < NI; i++) exp_q[i].push_back(v);
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic do_write(input logic [7:0] d);
        wr_en_s   = 1'b1;
        wr_data_s = d;
        @(negedge clk);
        wr_en_s   = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while ((busy_w != '0 || (level_w[0] | level_w[1] | level_w[2]) != 3'd0) && k < limit) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= limit) begin
            errors++;
            $display("FAIL idle_timeout: busy %b after %0d cycles, required idle", busy_w, k);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : stim
        int fall [NI];
        bit seen_hi [NI];
        int lows, s, len, k, n, inc, d, bb_before [NI];

        rst_n      = 1'b0;
        wr_en_s    = 1'b0;
        wr_data_s  = '0;
        baud_inc_s = 16'd16384;
        mon_en     = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset_txd_busy_full_ovf", i, int'({txd_w[i], busy_w[i], full_w[i], ovf_w[i]}), 8);
            chk("reset_level", i, int'(level_w[i]), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Idle-to-start latency, then asynchronous abort mid-frame.
        do_write(8'hA5);
        for (int i = 0; i < NI; i++) begin
            chk("write_level", i, int'(level_w[i]), 1);
            chk("write_txd_still_idle", i, int'(txd_w[i]), 1);
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("start_txd", i, int'(txd_w[i]), 0);
            chk("start_busy", i, int'(busy_w[i]), 1);
            chk("start_level", i, int'(level_w[i]), 0);
        end
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("async_reset_txd", i, int'(txd_w[i]), 1);
            chk("async_reset_busy", i, int'(busy_w[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (txd_w != '1 || busy_w != '0) lows++;
        end
        chk("no_frame_after_reset", 0, lows, 0);
        mon_en = 1'b1;

        // 8N1 / 7E2 / 7O2 timing at 4 clocks per bit, busy fall edge.
        baud_inc_s = 16'd16384;
        push_exp(8'h55, 16384);
        do_write(8'h55);
        for (int i = 0; i < NI; i++) begin
            fall[i] = -1; seen_hi[i] = 1'b0;
        end
        for (int m = 1; m <= 60; m++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (busy_w[i]) seen_hi[i] = 1'b1;
                else if (seen_hi[i] && fall[i] < 0) fall[i] = m;
            end
        end
        for (int i = 0; i < NI; i++) chk("busy_fall_clock", i, fall[i], frame_bits(i) * 4 + 1);
        wait_idle(2000);

        push_exp(8'h07, 16384);
        do_write(8'h07);
        wait_idle(2000);

        // Baud change mid-frame affects only the following frame.
        push_exp(8'h3C, 16384);
        push_exp(8'hC3, 8192);
        do_write(8'h3C);
        do_write(8'hC3);
        repeat (6) @(negedge clk);
        baud_inc_s = 16'd8192;
        wait_idle(3000);

        // FIFO full, overflow, back-to-back frames.
        baud_inc_s = 16'd16384;
        push_exp(8'h11, 16384);
        do_write(8'h11);
        repeat (4) @(negedge clk);
        for (int i = 0; i < NI; i++) bb_before[i] = b2b_cnt[i];
        for (int w = 0; w < 5; w++) begin
            if (w < 4) push_exp(8'(w + 1), 16384);
            wr_en_s   = 1'b1;
            wr_data_s = 8'(w + 1);
            @(negedge clk);
            if (w == 3) begin
                for (int i = 0; i < NI; i++) begin
                    chk("full_after_4th", i, int'(full_w[i]), 1);
                    chk("level_after_4th", i, int'(level_w[i]), 4);
                    chk("no_overflow_yet", i, int'(ovf_w[i]), 0);
                end
            end
        end
        wr_en_s = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk("overflow_pulse", i, int'(ovf_w[i]), 1);
            chk("level_after_drop", i, int'(level_w[i]), 4);
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk("overflow_one_cycle", i, int'(ovf_w[i]), 0);
        wait_idle(3000);
        for (int i = 0; i < NI; i++) chk("back_to_back_frames", i, b2b_cnt[i] - bb_before[i], 4);

        // Randomized bursts, constant increment within a burst.
        for (int r = 0; r < 20; r++) begin
            inc        = int'($urandom_range(4000, 65535));
            baud_inc_s = 16'(inc);
            n          = int'($urandom_range(1, 4));
            for (int j = 0; j < n; j++) begin
                d = int'($urandom_range(0, 255));
                push_exp(8'(d), inc);
                do_write(8'(d));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle(3000);
        end

        // Default increment: baud_inc = 0.
        baud_inc_s = 16'd0;
        push_exp(8'h55, 0);
        do_write(8'h55);
        k = 0;
        while (txd_w[0] != 1'b0 && k < 10) begin
            @(negedge clk); k++;
        end
        s = cyc;
        k = 0;
        while (busy_w[0] && k < 12000) begin
            @(negedge clk); k++;
        end
        len = cyc - s;
        checks++;
        if (len < 8730 || len > 8740) begin
            errors++;
            $display("FAIL default_inc_frame_len inst 0: got %0d clocks, required 8730..8740", len);
        end
        wait_idle(12000);

        for (int i = 0; i < NI; i++) chk("scoreboard_drained", i, exp_q[i].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
